// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default VGA mode timing, count widths and sync bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } vga_sync_t;

    // True when value lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input int value, input int lo, input int len);
        return (value >= lo) && (value < lo + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay
// Description : DEPTH-stage enable-gated shift pipe for the sync/blank bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay
    import vga_pkg::*;
#(
    parameter int        DEPTH   = 2,
    parameter vga_sync_t RST_VAL = '0
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_en,
    input  vga_sync_t i_sync,
    output vga_sync_t o_sync
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("sync_delay DEPTH must be at least 1");
        end
    endgenerate

    vga_sync_t r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else if (i_en) begin
            r_stage[0] <= i_sync;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Pixel-clock raster generator (counts, syncs, blank, frame start).
//               Optional macro VGA_SYNC_DELAY_EN delays sync/blank by SYNC_DELAY.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         pix_en_in,
    output logic [vga_pkg::HCOUNT_W-1:0] hcount_out,
    output logic [vga_pkg::VCOUNT_W-1:0] vcount_out,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         blank_out,
    output logic                         frame_start_out
);

    import vga_pkg::*;

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HCOUNT_W-1:0] c_h_last = HCOUNT_W'(c_h_total - 1);
    localparam logic [VCOUNT_W-1:0] c_v_last = VCOUNT_W'(c_v_total - 1);
    localparam vga_sync_t c_sync_rst = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, blank: 1'b0};

    generate
        if (c_h_total > 2048) begin : g_bad_h_total
            $error("H_TOTAL exceeds 2048");
        end
        if (c_v_total > 1024) begin : g_bad_v_total
            $error("V_TOTAL exceeds 1024");
        end
        if (SYNC_DELAY < 0) begin : g_bad_sync_delay
            $error("SYNC_DELAY must not be negative");
        end
    endgenerate

    logic [HCOUNT_W-1:0] r_hcount;
    logic [HCOUNT_W-1:0] w_hcount_nxt;
    logic [VCOUNT_W-1:0] r_vcount;
    logic [VCOUNT_W-1:0] w_vcount_nxt;
    logic                w_h_last;
    logic                w_v_last;
    logic                w_frame_start_nxt;
    logic                r_frame_start;
    vga_sync_t           w_sync_nxt;
    vga_sync_t           r_sync;
    vga_sync_t           w_sync_out;

    always_comb begin
        w_h_last     = (r_hcount == c_h_last);
        w_v_last     = (r_vcount == c_v_last);
        w_hcount_nxt = w_h_last ? '0 : r_hcount + 1'b1;
        w_vcount_nxt = r_vcount;
        if (w_h_last) begin
            w_vcount_nxt = w_v_last ? '0 : r_vcount + 1'b1;
        end
    end

    // Decode from the next count so every registered output matches the count it ships with.
    always_comb begin
        w_sync_nxt.hsync  = in_window(int'(w_hcount_nxt), H_ACTIVE + H_FP, H_SYNC)
                            ? SYNC_POL : ~SYNC_POL;
        w_sync_nxt.vsync  = in_window(int'(w_vcount_nxt), V_ACTIVE + V_FP, V_SYNC)
                            ? SYNC_POL : ~SYNC_POL;
        w_sync_nxt.blank  = (int'(w_hcount_nxt) >= H_ACTIVE) || (int'(w_vcount_nxt) >= V_ACTIVE);
        w_frame_start_nxt = (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_sync        <= c_sync_rst;
            r_frame_start <= 1'b0;
        end else if (pix_en_in) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_sync        <= w_sync_nxt;
            r_frame_start <= w_frame_start_nxt;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    sync_delay #(
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (c_sync_rst)
    ) u_sync_delay (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_en    (pix_en_in),
        .i_sync  (r_sync),
        .o_sync  (w_sync_out)
    );
`else
    assign w_sync_out = r_sync;
`endif

    assign hcount_out      = r_hcount;
    assign vcount_out      = r_vcount;
    assign hsync_out       = w_sync_out.hsync;
    assign vsync_out       = w_sync_out.vsync;
    assign blank_out       = w_sync_out.blank;
    assign frame_start_out = r_frame_start;

endmodule
`default_nettype wire
